// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a multiplexed 7-segment scan bus: recovers the
// eight displayed characters and publishes them as one frame. Define SEG_DECODE_HEX_EN to accept A-F glyphs.
module seg_scan_decoder #(
    parameter int STABLE_CNT = 16,
    parameter int TIMEOUT    = 200000
) (
    input  logic        clk_100m,
    input  logic        cr,
    input  logic [7:0]  pos,
    input  logic [6:0]  seg,
    output logic [31:0] digits,
    output logic [7:0]  blank_mask,
    output logic [7:0]  err_mask,
    output logic        frame_valid,
    output logic        seg_err,
    output logic        stale
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HELD
    } state_e;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } dec_t;

    localparam logic [7:0]  STABLE_LAST = 8'(STABLE_CNT - 1);
    localparam logic [19:0] TIMEOUT_V   = 20'(TIMEOUT);

    function automatic dec_t decode(input logic [6:0] pat);
        dec_t r;
        r = '{nib: 4'h0, blank: 1'b0, err: 1'b0};
        case (pat)
            7'h3F: r.nib = 4'h0;
            7'h06: r.nib = 4'h1;
            7'h5B: r.nib = 4'h2;
            7'h4F: r.nib = 4'h3;
            7'h66: r.nib = 4'h4;
            7'h6D: r.nib = 4'h5;
            7'h7D: r.nib = 4'h6;
            7'h07: r.nib = 4'h7;
            7'h7F: r.nib = 4'h8;
            7'h6F: r.nib = 4'h9;
            7'h00: r.blank = 1'b1;
`ifdef SEG_DECODE_HEX_EN
            7'h77: r.nib = 4'hA;
            7'h7C: r.nib = 4'hB;
            7'h39: r.nib = 4'hC;
            7'h5E: r.nib = 4'hD;
            7'h79: r.nib = 4'hE;
            7'h71: r.nib = 4'hF;
`endif
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Two-flop synchronisers plus the previous synced sample for change detection
    logic [7:0]  pos_meta_q, pos_meta_d;
    logic [7:0]  pos_sync_q, pos_sync_d;
    logic [6:0]  seg_meta_q, seg_meta_d;
    logic [6:0]  seg_sync_q, seg_sync_d;
    logic [7:0]  prev_pos_q, prev_pos_d;
    logic [6:0]  prev_seg_q, prev_seg_d;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [19:0] to_cnt_q, to_cnt_d;

    logic [31:0] work_digits_q, work_digits_d;
    logic [7:0]  work_blank_q, work_blank_d;
    logic [7:0]  work_err_q, work_err_d;
    logic [7:0]  seen_q, seen_d;

    logic [31:0] digits_q, digits_d;
    logic [7:0]  blank_mask_q, blank_mask_d;
    logic [7:0]  err_mask_q, err_mask_d;
    logic        frame_valid_q, frame_valid_d;
    logic        seg_err_q, seg_err_d;

    logic [7:0]  sel;
    logic        pos_ok;
    logic        changed;
    logic        capture;
    dec_t        dec;
    logic [7:0]  seen_base;

    always_comb begin
        sel     = ~pos_sync_q;
        pos_ok  = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
        changed = (pos_sync_q != prev_pos_q) || (seg_sync_q != prev_seg_q);
        dec     = decode(~seg_sync_q);
    end

    always_comb begin
        pos_meta_d = pos;
        pos_sync_d = pos_meta_q;
        seg_meta_d = seg;
        seg_sync_d = seg_meta_q;
        prev_pos_d = pos_sync_q;
        prev_seg_d = seg_sync_q;
    end

    // Stability FSM: a digit is accepted once the same sample has been seen STABLE_CNT times
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (pos_ok) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            ST_SETTLE: begin
                if (!pos_ok) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (changed) begin
                    cnt_d = 8'd1;
                end else if (cnt_q == STABLE_LAST) begin
                    capture = 1'b1;
                    state_d = ST_HELD;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_HELD: begin
                if (!pos_ok) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (changed) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        work_digits_d = work_digits_q;
        work_blank_d  = work_blank_q;
        work_err_d    = work_err_q;
        digits_d      = digits_q;
        blank_mask_d  = blank_mask_q;
        err_mask_d    = err_mask_q;
        frame_valid_d = 1'b0;
        seen_base     = seen_q;

        // Publish the frame using slot contents from before any same-cycle capture
        if (seen_q == 8'hFF) begin
            digits_d      = work_digits_q;
            blank_mask_d  = work_blank_q;
            err_mask_d    = work_err_q;
            frame_valid_d = 1'b1;
            seen_base     = 8'h00;
        end

        for (int i = 0; i < 8; i++) begin
            if (capture && sel[i]) begin
                work_digits_d[4*i +: 4] = dec.nib;
                work_blank_d[i]         = dec.blank;
                work_err_d[i]           = dec.err;
            end
        end
        seen_d = seen_base | (capture ? sel : 8'h00);

        seg_err_d = seg_err_q | (capture & dec.err);

        if (capture) begin
            to_cnt_d = 20'd0;
        end else if (to_cnt_q == TIMEOUT_V) begin
            to_cnt_d = to_cnt_q;
        end else begin
            to_cnt_d = to_cnt_q + 20'd1;
        end
    end

    always_ff @(posedge clk_100m) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (cr) begin
            pos_meta_q    <= 8'hFF;
            pos_sync_q    <= 8'hFF;
            seg_meta_q    <= 7'h7F;
            seg_sync_q    <= 7'h7F;
            prev_pos_q    <= 8'hFF;
            prev_seg_q    <= 7'h7F;
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            to_cnt_q      <= 20'd0;
            // NOTE: working slots are reset too, so a partial frame can never leak out after cr.
            work_digits_q <= 32'h0;
            work_blank_q  <= 8'h00;
            work_err_q    <= 8'h00;
            seen_q        <= 8'h00;
            digits_q      <= 32'h0;
            blank_mask_q  <= 8'h00;
            err_mask_q    <= 8'h00;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
        end else begin
            pos_meta_q    <= pos_meta_d;
            pos_sync_q    <= pos_sync_d;
            seg_meta_q    <= seg_meta_d;
            seg_sync_q    <= seg_sync_d;
            prev_pos_q    <= prev_pos_d;
            prev_seg_q    <= prev_seg_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            work_digits_q <= work_digits_d;
            work_blank_q  <= work_blank_d;
            work_err_q    <= work_err_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            blank_mask_q  <= blank_mask_d;
            err_mask_q    <= err_mask_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
        end
    end

    assign digits      = digits_q;
    assign blank_mask  = blank_mask_q;
    assign err_mask    = err_mask_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign stale       = (to_cnt_q == TIMEOUT_V);

endmodule
